// File: rtl/mem_copy_engine.sv
// Block copy initiator: streams words from the read port to the write port through one pipeline register.
// Optional macro DESCEND_EN: descending copy when dst > src, for overlap-safe forward moves.
module mem_copy_engine #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DEPTH-1:0] src_i,
  input  logic [DEPTH-1:0] dst_i,
  input  logic [DEPTH:0]   len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DEPTH:0]   count_o,
  output logic             rd_en_o,
  output logic [DEPTH-1:0] addr_rd_o,
  input  logic [WIDTH-1:0] data_rd_i,
  output logic             wr_en_o,
  output logic [DEPTH-1:0] addr_wr_o,
  output logic [WIDTH-1:0] data_wr_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [DEPTH:0] MAX_LEN = (DEPTH+1)'(1) << DEPTH;

  state_t           state_q;
  logic             desc_q;
  logic [DEPTH:0]   remain_q;
  logic [DEPTH-1:0] wr_ptr_q;
  logic             busy_q, done_q, rd_en_q, wr_en_q;
  logic [DEPTH:0]   count_q;
  logic [DEPTH-1:0] addr_rd_q, addr_wr_q;
  logic [WIDTH-1:0] data_wr_q;

  logic [DEPTH:0]   len_d;
  logic             desc_d;
  logic [DEPTH-1:0] len_m1_d, rd_start_d, wr_start_d;
  logic [DEPTH-1:0] rd_next_d, wr_next_d;

  assign len_d = (len_i > MAX_LEN) ? MAX_LEN : len_i;

`ifdef DESCEND_EN
  assign desc_d = (dst_i > src_i);
`else
  assign desc_d = 1'b0;
`endif

  // Descending copies begin at the last word of each block.
  assign len_m1_d   = len_d[DEPTH-1:0] - 1'b1;
  assign rd_start_d = desc_d ? src_i + len_m1_d : src_i;
  assign wr_start_d = desc_d ? dst_i + len_m1_d : dst_i;
  assign rd_next_d  = desc_q ? addr_rd_q - 1'b1 : addr_rd_q + 1'b1;
  assign wr_next_d  = desc_q ? wr_ptr_q - 1'b1 : wr_ptr_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      desc_q    <= 1'b0;
      remain_q  <= '0;
      wr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      count_q   <= '0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            desc_q   <= desc_d;
            count_q  <= '0;
            busy_q   <= 1'b1;
            wr_ptr_q <= wr_start_d;
            if (len_d == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              rd_en_q   <= 1'b1;
              addr_rd_q <= rd_start_d;
              remain_q  <= len_d - 1'b1;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          count_q   <= count_q + {{DEPTH{1'b0}}, wr_en_q};
          data_wr_q <= data_rd_i;
          wr_en_q   <= 1'b1;
          addr_wr_q <= wr_ptr_q;
          wr_ptr_q  <= wr_next_d;
          if (remain_q == '0) begin
            rd_en_q   <= 1'b0;
            addr_rd_q <= '0;
            state_q   <= DRAIN;
          end else begin
            addr_rd_q <= rd_next_d;
            remain_q  <= remain_q - 1'b1;
          end
        end
        DRAIN: begin
          // The final word was written during this cycle.
          count_q   <= count_q + {{DEPTH{1'b0}}, wr_en_q};
          wr_en_q   <= 1'b0;
          addr_wr_q <= '0;
          data_wr_q <= '0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign count_o   = count_q;
  assign rd_en_o   = rd_en_q;
  assign addr_rd_o = addr_rd_q;
  assign wr_en_o   = wr_en_q;
  assign addr_wr_o = addr_wr_q;
  assign data_wr_o = data_wr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural dual-port memory, read/write scoreboards, vector table plus corner sequences.
module tb_mem_copy_engine;

  localparam int W = 64;
  localparam int D = 4;

  logic         clk, rst, start;
  logic [D-1:0] src, dst;
  logic [D:0]   len;
  logic         busy_o, done_o, rd_en_o, wr_en_o;
  logic [D:0]   count_o;
  logic [D-1:0] addr_rd_o, addr_wr_o;
  logic [W-1:0] data_rd_i, data_wr_o;

  logic [W-1:0] mem [16];
  logic         load_en;
  logic [D-1:0] load_addr;
  logic [W-1:0] load_data;

  logic [D-1:0]   exp_rd_q [$];
  logic [D+W-1:0] exp_wr_q [$];
  logic [D-1:0]   er;
  logic [D+W-1:0] ew;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [D-1:0] src;
    logic [D-1:0] dst;
    logic [D:0]   len;
    int           poke;
    int           exp_lat;
    int           exp_cnt;
  } vec_t;
  vec_t vecs[12];

  mem_copy_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o),
    .rd_en_o(rd_en_o), .addr_rd_o(addr_rd_o), .data_rd_i(data_rd_i),
    .wr_en_o(wr_en_o), .addr_wr_o(addr_wr_o), .data_wr_o(data_wr_o)
  );

  // clock/reset and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_rd_i = mem[addr_rd_o];
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (wr_en_o) mem[addr_wr_o] <= data_wr_o;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en_o) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", {1'b1, addr_rd_o}, 0);
        else begin
          er = exp_rd_q.pop_front();
          chk("rd_addr", addr_rd_o, er);
        end
      end else chk("rd_addr_idle", addr_rd_o, 0);
      if (wr_en_o) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {1'b1, addr_wr_o, data_wr_o}, 0);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr_data", {addr_wr_o, data_wr_o}, ew);
        end
      end else chk("wr_idle", {addr_wr_o, data_wr_o}, 0);
    end
  end

  // driver tasks
  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = D'(i); load_data = {$urandom, $urandom};
      @(posedge clk);
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic poke_word(input logic [D-1:0] a, input logic [W-1:0] v);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Reference: a read in cycle k+1 sees writes of words j <= k-2 only.
  task automatic model(input logic [D-1:0] s, input logic [D-1:0] d, input int L);
    logic [W-1:0] ref_m [16];
    logic [W-1:0] val [16];
    logic [D-1:0] ra [16];
    logic [D-1:0] wa [16];
    bit desc;
    desc = 1'b0;
`ifdef DESCEND_EN
    desc = (d > s);
`endif
    for (int i = 0; i < 16; i++) ref_m[i] = mem[i];
    for (int k = 0; k < L; k++) begin
      ra[k] = desc ? D'(int'(s) + L - 1 - k) : D'(int'(s) + k);
      wa[k] = desc ? D'(int'(d) + L - 1 - k) : D'(int'(d) + k);
      if (k >= 2) ref_m[wa[k-2]] = val[k-2];
      val[k] = ref_m[ra[k]];
      exp_rd_q.push_back(ra[k]);
    end
    for (int k = 0; k < L; k++) exp_wr_q.push_back({wa[k], val[k]});
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after DONE.
  task automatic run_copy(input logic [D-1:0] s, input logic [D-1:0] d, input logic [D:0] l,
                          input int poke, input int exp_lat, input int exp_cnt);
    int L, got;
    L = (l > 16) ? 16 : int'(l);
    model(s, d, L);
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int c = 1; c <= 40 && got == 0; c++) begin
      @(negedge clk);
      if (c == poke) begin
        start = 1'b1; src = ~s; dst = ~d; len = 5'd3;
      end else start = 1'b0;
      chk("busy_during", busy_o, 1);
      if (done_o) begin
        got = c;
        chk("done_latency", c, exp_lat);
        chk("count_at_done", count_o, exp_cnt);
      end
    end
    if (got == 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", busy_o, 0);
    chk("done_pulse_width", done_o, 0);
    chk("count_hold", count_o, exp_cnt);
    chk("rd_q_drained", exp_rd_q.size(), 0);
    chk("wr_q_drained", exp_wr_q.size(), 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  logic [W-1:0] snap [16];

  initial begin
    vecs[0]  = '{src: 4'd0,  dst: 4'd8,  len: 5'd4,  poke: 0, exp_lat: 6,  exp_cnt: 4};
    vecs[1]  = '{src: 4'd3,  dst: 4'd3,  len: 5'd0,  poke: 0, exp_lat: 1,  exp_cnt: 0};
    vecs[2]  = '{src: 4'd14, dst: 4'd2,  len: 5'd4,  poke: 0, exp_lat: 6,  exp_cnt: 4};
    vecs[3]  = '{src: 4'd5,  dst: 4'd0,  len: 5'd31, poke: 0, exp_lat: 18, exp_cnt: 16};
    vecs[4]  = '{src: 4'd1,  dst: 4'd9,  len: 5'd6,  poke: 2, exp_lat: 8,  exp_cnt: 6};
    vecs[5]  = '{src: 4'd7,  dst: 4'd6,  len: 5'd5,  poke: 0, exp_lat: 7,  exp_cnt: 5};
    vecs[6]  = '{src: 4'd9,  dst: 4'd10, len: 5'd3,  poke: 0, exp_lat: 5,  exp_cnt: 3};
    vecs[7]  = '{src: 4'd0,  dst: 4'd0,  len: 5'd16, poke: 0, exp_lat: 18, exp_cnt: 16};
    vecs[8]  = '{src: 4'd2,  dst: 4'd4,  len: 5'd17, poke: 5, exp_lat: 18, exp_cnt: 16};
    for (int i = 9; i < 12; i++) begin
      vecs[i].src  = D'($urandom_range(0, 15));
      vecs[i].dst  = D'($urandom_range(0, 15));
      vecs[i].len  = 5'($urandom_range(1, 16));
      vecs[i].poke = 0;
      vecs[i].exp_lat = int'(vecs[i].len) + 2;
      vecs[i].exp_cnt = int'(vecs[i].len);
    end

    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_rd", {rd_en_o, addr_rd_o}, 0);
    chk("rst_wr", {wr_en_o, addr_wr_o, data_wr_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      preload();
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].poke, vecs[i].exp_lat, vecs[i].exp_cnt);
    end

    // back-to-back: second start lands in the cycle after DONE
    preload();
    run_copy(4'd3, 4'd12, 5'd2, 0, 4, 2);
    run_copy(4'd12, 4'd6, 5'd3, 0, 5, 3);

    // overlap: dst = src + 2
    preload();
    poke_word(4'd0, 64'd1);
    poke_word(4'd1, 64'd2);
    poke_word(4'd2, 64'd3);
    poke_word(4'd3, 64'd4);
    run_copy(4'd0, 4'd2, 5'd4, 0, 6, 4);
`ifdef DESCEND_EN
    chk("overlap_m2", mem[2], 64'd1);
    chk("overlap_m3", mem[3], 64'd2);
    chk("overlap_m4", mem[4], 64'd3);
    chk("overlap_m5", mem[5], 64'd4);
`else
    chk("overlap_m2", mem[2], 64'd1);
    chk("overlap_m3", mem[3], 64'd2);
    chk("overlap_m4", mem[4], 64'd1);
    chk("overlap_m5", mem[5], 64'd2);
`endif

    // reset in cycle 3 of a len-8 copy: only word 0 lands
    preload();
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    exp_rd_q.push_back(4'd0);
    exp_rd_q.push_back(4'd1);
    exp_wr_q.push_back({4'd8, mem[0]});
    start = 1'b1; src = 4'd0; dst = 4'd8; len = 5'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_count", count_o, 0);
    chk("midrst_rd", {rd_en_o, addr_rd_o}, 0);
    chk("midrst_wr", {wr_en_o, addr_wr_o, data_wr_o}, 0);
    chk("midrst_rd_q", exp_rd_q.size(), 0);
    chk("midrst_wr_q", exp_wr_q.size(), 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_done", done_o, 0);
    end
    chk("midrst_mem8", mem[8], snap[0]);
    for (int i = 9; i < 16; i++) chk("midrst_mem_untouched", mem[i], snap[i]);

    // engine still usable after the abort
    preload();
    run_copy(4'd10, 4'd1, 5'd5, 0, 7, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Data-memory copy initiator for the pipelined core: on a start pulse it copies a block of words from a source address to a destination address using the dual-port data memory's independent read and write ports. One word per cycle is streamed through a single pipeline register, so the memory's combinational read and synchronous write overlap. It sits beside the data memory as a second requestor and owns both memory ports while busy.

## Interface
- width, 64, data word width; must match the data memory
- depth, 4, address bits; the memory holds 2**depth words
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request a copy; sampled only in IDLE
- src_i  in  depth  first source word address
- dst_i  in  depth  first destination word address
- len_i  in  depth+1  words to copy; values above 2**depth are clamped to 2**depth
- busy_o  out  1  high from the first cycle after accept through the DONE cycle
- done_o  out  1  one-cycle completion pulse
- count_o  out  depth+1  words written in the current or last copy
- rd_en_o  out  1  memory read enable
- addr_rd_o  out  depth  memory read address
- data_rd_i  in  width  memory read data (combinational from addr_rd_o)
- wr_en_o  out  1  memory write enable
- addr_wr_o  out  depth  memory write address
- data_wr_o  out  width  memory write data

## Operation
- All outputs are registered. Reset value of every output is 0; state IDLE.
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start_i=1, latch src/dst/clamped len, clear count_o, choose direction; len=0 goes to DONE, else goes to READ. start_i asserted in any other state is ignored.
- READ: rd_en_o=1 at the current read address; data_rd_i is captured into the pipeline register at the clock edge. From the second READ cycle onward, wr_en_o=1 writes the previously captured word. After the last read, go to DRAIN.
- DRAIN: rd_en_o=0; final write issued; go to DONE.
- DONE: done_o=1 for one cycle, wr_en_o=0; return to IDLE.
- count_o increments on every cycle with wr_en_o=1 and holds after DONE until the next accept.
- When their enable is low, addr_rd_o, addr_wr_o and data_wr_o are driven to 0.
- Address arithmetic is modulo 2**depth: src+k and dst+k wrap silently. count_o never wraps because len is at most 2**depth.
- Ascending copies with dst = src+1 are correct because a read precedes the same-edge write. A forward overlap with dst >= src+2 replicates the leading words; this is the defined behaviour when DESCEND_EN is absent.
- Reset mid-copy: all outputs return to 0 immediately. Words already written stay in memory, and no done_o is produced.

## Timing
- Accept edge = cycle 0. Read of word k (0..L-1) occurs in cycle k+1. Write of word k occurs in cycle k+2. DRAIN is cycle L+1, DONE is cycle L+2.
- Latency from accept to done_o = L+2 cycles. len=0 gives done_o in cycle 1 with no memory access.
- Throughput is 1 word per cycle. The earliest next accept is the cycle after DONE.

## Configuration
- DESCEND_EN defined: when dst_i > src_i (unsigned compare of raw inputs), the copy starts at src+L-1 and dst+L-1 and decrements both addresses, giving memmove-safe forward overlap. Otherwise the copy is ascending.
- DESCEND_EN undefined: the copy is always ascending and no comparator is built.

## Test plan
- Copy mem[0..3] = {A,B,C,D} to dst 8, len 4 -> writes 8..11 in cycles 2..5 with data A..D; done_o in cycle 6; count_o = 4; busy_o high in cycles 1..6.
- len_i = 0 -> done_o in cycle 1; rd_en_o and wr_en_o never assert; count_o = 0.
- src 14, dst 2, len 4 -> reads 14, 15, 0, 1, then writes 2..5 (wrap-around); len_i = 31 is clamped to 16 and gives done_o in cycle 18.
- start_i pulsed while busy -> ignored; transfer completes unchanged; a new start in the cycle after DONE is accepted.
- rst_i asserted in cycle 3 of a len-8 copy -> all outputs read 0 asynchronously; memory holds exactly the words written in cycle 2; no done_o.
- Overlap test with src 0 = {1,2,3,4}, dst 2, len 4 -> with DESCEND_EN, mem[2..5] = {1,2,3,4}; without DESCEND_EN, mem[2..5] = {1,2,1,2}.
